// File: rtl/fetch_control_unit.sv
// Fetch control FSM: branch/jump redirect, load-use stall, debug hold, saturating perf counters.
// Outputs are combinational in the current cycle; optional halt-on-all-ones opcode under FCU_HALT_EN.
module fetch_control_unit #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic              id_ex_memread,
  input  logic [4:0]        id_ex_rt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              hold_req,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              stall,
  output logic              stall_pm,
  output logic              flush,
  output logic              id_bubble,
  output logic              halted,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    HOLD    = 2'b10,
    HALT    = 2'b11
  } state_t;

  state_t cur_state, nxt_state;
  logic   hazard;
  logic   is_jump;
  logic   is_halt;

  assign hazard  = id_ex_memread && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == ins[25:21]) || (id_ex_rt == ins[20:16]));
  assign is_jump = (ins[31:26] == 6'b000010);

`ifdef FCU_HALT_EN
  assign is_halt = (ins == 32'hFFFF_FFFF);
`else
  assign is_halt = 1'b0;
`endif

  always_comb begin
    nxt_state  = cur_state;
    pc_mux_sel = 1'b0;
    jmp_loc    = '0;
    stall      = 1'b0;
    stall_pm   = 1'b0;
    flush      = 1'b0;
    id_bubble  = 1'b0;
    halted     = 1'b0;
    case (cur_state)
      RUN: begin
        if (branch_taken) begin
          pc_mux_sel = 1'b1;
          jmp_loc    = branch_target;
          flush      = 1'b1;
        end else if (hold_req) begin
          stall     = 1'b1;
          stall_pm  = 1'b1;
          nxt_state = HOLD;
        end else if (is_halt) begin
          stall     = 1'b1;
          stall_pm  = 1'b1;
          nxt_state = HALT;
        end else if (hazard) begin
          stall     = 1'b1;
          stall_pm  = 1'b1;
          id_bubble = 1'b1;
          nxt_state = LDSTALL;
        end else if (is_jump) begin
          pc_mux_sel = 1'b1;
          jmp_loc    = ins[ADDR_W-1:0];
        end
      end
      // The bubble is already in ID/EX, so hazard detection is skipped here.
      LDSTALL: begin
        nxt_state = RUN;
        if (branch_taken) begin
          pc_mux_sel = 1'b1;
          jmp_loc    = branch_target;
          flush      = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_mux_sel = 1'b1;
          jmp_loc    = branch_target;
          flush      = 1'b1;
          nxt_state  = RUN;
        end else if (hold_req) begin
          stall    = 1'b1;
          stall_pm = 1'b1;
        end else begin
          nxt_state = RUN;
        end
      end
      default: begin
`ifdef FCU_HALT_EN
        stall     = 1'b1;
        stall_pm  = 1'b1;
        halted    = 1'b1;
        nxt_state = HALT;
`else
        nxt_state = RUN;
`endif
      end
    endcase

    // Reset silences every output immediately, independent of the clock.
    if (!reset) begin
      pc_mux_sel = 1'b0;
      jmp_loc    = '0;
      stall      = 1'b0;
      stall_pm   = 1'b0;
      flush      = 1'b0;
      id_bubble  = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit: expected outputs queued per cycle, popped and compared at negedge.
module tb_fetch_control_unit;

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_LD   = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rt;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        hold_req;
  logic        pc_mux_sel;
  logic [15:0] jmp_loc;
  logic        stall, stall_pm, flush, id_bubble, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  fetch_control_unit #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ins(ins), .id_ex_memread(id_ex_memread),
    .id_ex_rt(id_ex_rt), .branch_taken(branch_taken), .branch_target(branch_target),
    .hold_req(hold_req), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .stall(stall),
    .stall_pm(stall_pm), .flush(flush), .id_bubble(id_bubble), .halted(halted),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pms;
    logic [15:0] jl;
    logic        st, stpm, fl, bub, hlt;
    logic [1:0]  s;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_sc = '0;
  logic [15:0] m_fc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic mr, input logic [4:0] rt,
                       input logic bt, input logic [15:0] tgt, input logic hr);
    ins = i; id_ex_memread = mr; id_ex_rt = rt;
    branch_taken = bt; branch_target = tgt; hold_req = hr;
  endtask

  // Queue this cycle's expectation, advance the counter model, then compare at negedge.
  task automatic cyc(input string tag, input logic pms, input logic [15:0] jl,
                     input logic st, input logic stpm, input logic fl, input logic bub,
                     input logic hlt, input logic [1:0] s);
    exp_t e;
    e.tag = tag; e.pms = pms; e.jl = jl; e.st = st; e.stpm = stpm;
    e.fl = fl; e.bub = bub; e.hlt = hlt; e.s = s; e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);
    if (st && m_sc != 16'hFFFF) m_sc++;
    if (fl && m_fc != 16'hFFFF) m_fc++;
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, ".pc_mux_sel"}, pc_mux_sel, e.pms);
    check({e.tag, ".jmp_loc"},    jmp_loc,    e.jl);
    check({e.tag, ".stall"},      stall,      e.st);
    check({e.tag, ".stall_pm"},   stall_pm,   e.stpm);
    check({e.tag, ".flush"},      flush,      e.fl);
    check({e.tag, ".id_bubble"},  id_bubble,  e.bub);
    check({e.tag, ".halted"},     halted,     e.hlt);
    check({e.tag, ".state"},      state,      e.s);
    check({e.tag, ".stall_cnt"},  stall_cnt,  e.sc);
    check({e.tag, ".flush_cnt"},  flush_cnt,  e.fc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with every input active: outputs must still be silent.
    reset = 1'b0;
    drive(32'h0800_0040, 1'b1, 5'd5, 1'b1, 16'h0123, 1'b1);
    cyc("rst", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);
    reset = 1'b1;
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("idle", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    // Load-use on rs, then on rt; no hazard for rt=0 or when not a load.
    drive(32'h00A7_0000, 1, 5'd5, 0, 16'h0, 0);
    cyc("ld_rs", 0, 16'h0, 1, 1, 0, 1, 0, S_RUN);
    cyc("ld_rs_ldstall", 0, 16'h0, 0, 0, 0, 0, 0, S_LD);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("ld_rs_back", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);
    drive(32'h00A7_0000, 1, 5'd7, 0, 16'h0, 0);
    cyc("ld_rt", 0, 16'h0, 1, 1, 0, 1, 0, S_RUN);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("ld_rt_ldstall", 0, 16'h0, 0, 0, 0, 0, 0, S_LD);
    drive(32'h0, 1, 5'd0, 0, 16'h0, 0);
    cyc("rt_zero", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);
    drive(32'h00A7_0000, 0, 5'd5, 0, 16'h0, 0);
    cyc("no_load", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    drive(32'h0800_0040, 0, 0, 0, 16'h0, 0);
    cyc("jump", 1, 16'h0040, 0, 0, 0, 0, 0, S_RUN);

    // Branch beats a simultaneous hazard, and beats a jump.
    drive(32'h00A7_0000, 1, 5'd5, 1, 16'h0123, 0);
    cyc("br_haz", 1, 16'h0123, 0, 0, 1, 0, 0, S_RUN);
    drive(32'h0800_0040, 0, 0, 1, 16'h0077, 0);
    cyc("br_jmp", 1, 16'h0077, 0, 0, 1, 0, 0, S_RUN);

    // Branch resolved while in LDSTALL.
    drive(32'h00A7_0000, 1, 5'd5, 0, 16'h0, 0);
    cyc("br_ld_a", 0, 16'h0, 1, 1, 0, 1, 0, S_RUN);
    drive(32'h00A7_0000, 1, 5'd5, 1, 16'h0200, 0);
    cyc("br_ld_b", 1, 16'h0200, 0, 0, 1, 0, 0, S_LD);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("br_ld_c", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    // Hold for four cycles.
    drive(32'h0, 0, 0, 0, 16'h0, 1);
    cyc("hold1", 0, 16'h0, 1, 1, 0, 0, 0, S_RUN);
    for (int i = 0; i < 3; i++)
      cyc("holdn", 0, 16'h0, 1, 1, 0, 0, 0, S_HOLD);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("hold_rel", 0, 16'h0, 0, 0, 0, 0, 0, S_HOLD);
    cyc("hold_run", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    // Branch resolved while in HOLD.
    drive(32'h0, 0, 0, 0, 16'h0, 1);
    cyc("br_hold_a", 0, 16'h0, 1, 1, 0, 0, 0, S_RUN);
    drive(32'h0, 0, 0, 1, 16'h0300, 1);
    cyc("br_hold_b", 1, 16'h0300, 0, 0, 1, 0, 0, S_HOLD);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("br_hold_c", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    // Reset pulsed during HOLD.
    drive(32'h0, 0, 0, 0, 16'h0, 1);
    cyc("rhold_a", 0, 16'h0, 1, 1, 0, 0, 0, S_RUN);
    cyc("rhold_b", 0, 16'h0, 1, 1, 0, 0, 0, S_HOLD);
    reset = 1'b0;
    m_sc = '0;
    m_fc = '0;
    cyc("rhold_rst", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);
    reset = 1'b1;
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("rhold_after", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

    // Stall counter saturation.
    drive(32'h0, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 65540; i++) begin
      if (m_sc != 16'hFFFF) m_sc++;
      @(posedge clk);
    end
    #1;
    cyc("sat_a", 0, 16'h0, 1, 1, 0, 0, 0, S_HOLD);
    cyc("sat_b", 0, 16'h0, 1, 1, 0, 0, 0, S_HOLD);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("sat_rel", 0, 16'h0, 0, 0, 0, 0, 0, S_HOLD);
    cyc("sat_run", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);

`ifdef FCU_HALT_EN
    drive(32'hFFFF_FFFF, 0, 0, 0, 16'h0, 0);
    cyc("halt_enter", 0, 16'h0, 1, 1, 0, 0, 0, S_RUN);
    drive(32'h0, 0, 0, 1, 16'h0456, 1);
    cyc("halt_br", 0, 16'h0, 1, 1, 0, 0, 1, S_HALT);
    drive(32'h0, 0, 0, 0, 16'h0, 0);
    cyc("halt_stay", 0, 16'h0, 1, 1, 0, 0, 1, S_HALT);
`else
    drive(32'hFFFF_FFFF, 0, 0, 0, 16'h0, 0);
    cyc("ones_a", 0, 16'h0, 0, 0, 0, 0, 0, S_RUN);
    drive(32'h0, 0, 0, 1, 16'h0456, 0);
    cyc("ones_b", 1, 16'h0456, 0, 0, 1, 0, 0, S_RUN);
`endif

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_control_unit.md
FETCH_CONTROL_UNIT -- requirements
Module: fetch_control_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 16, program-address width (matches fetch-stage address bus).
REQ-002 SHALL have parameter: CNT_W, 16, width of performance counters.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: ins  input  32  instruction currently presented by the fetch stage.
REQ-006 SHALL have port: id_ex_memread  input  1  instruction in ID/EX is a load.
REQ-007 SHALL have port: id_ex_rt  input  5  destination register of that load.
REQ-008 SHALL have port: branch_taken  input  1  execute stage resolved a taken branch this cycle.
REQ-009 SHALL have port: branch_target  input  ADDR_W  resolved branch target.
REQ-010 SHALL have port: hold_req  input  1  external (debug) fetch freeze request.
REQ-011 SHALL have ports: pc_mux_sel  output  1; jmp_loc  output  ADDR_W  redirect select and target for the fetch stage.
REQ-012 SHALL have ports: stall  output  1; stall_pm  output  1  repeat current address / hold the fetched instruction.
REQ-013 SHALL have ports: flush  output  1; id_bubble  output  1  kill the IF/ID instruction / zero the ID/EX controls.
REQ-014 SHALL have ports: halted  output  1; state  output  2; stall_cnt  output  CNT_W; flush_cnt  output  CNT_W.

Function
REQ-015 SHALL implement FSM state encoding RUN=00, LDSTALL=01, HOLD=10, HALT=11, and drive it on port state.
REQ-016 SHALL compute the RUN-state outputs combinationally, in this priority order: branch_taken, hold_req, halt opcode, load-use hazard, jump.
REQ-017 SHALL, on branch_taken in any state other than HALT, assert pc_mux_sel=1, jmp_loc=branch_target and flush=1 in that same cycle, then go to RUN.
REQ-018 SHALL, on hold_req in RUN, assert stall=1 and stall_pm=1, and go to HOLD.
REQ-019 SHALL keep stall=1 and stall_pm=1 in HOLD while hold_req=1; on the cycle hold_req=0 it deasserts both and returns to RUN.
REQ-020 SHALL detect a load-use hazard when id_ex_memread=1, id_ex_rt!=0 and id_ex_rt equals ins[25:21] or ins[20:16].
REQ-021 SHALL, on a load-use hazard in RUN, assert stall=1, stall_pm=1 and id_bubble=1 in that cycle, then go to LDSTALL.
REQ-022 SHALL, in LDSTALL, drive all outputs 0, not evaluate hazard detection, and return to RUN after exactly one cycle (branch_taken still applies per REQ-017).
REQ-023 SHALL treat ins[31:26]=6'b000010 in RUN, with no higher-priority event, as a jump: pc_mux_sel=1, jmp_loc=ins[ADDR_W-1:0], no flush and no stall.
REQ-024 SHALL drive jmp_loc=0 whenever pc_mux_sel=0.
REQ-025 SHALL increment stall_cnt on each cycle with stall=1, and flush_cnt on each cycle with flush=1; both saturate at all-ones and do not wrap.

Reset
REQ-026 SHALL, on reset=0, immediately force state=RUN, stall_cnt=0 and flush_cnt=0, with all outputs 0 regardless of clk.
REQ-027 SHALL abandon any HOLD, LDSTALL or HALT condition when reset is asserted mid-operation; the first cycle after release is RUN.

Configuration
REQ-028 SHALL, with FCU_HALT_EN defined, treat ins=32'hFFFFFFFF in RUN (no branch_taken or hold_req) as a halt: go to HALT, where stall=1, stall_pm=1 and halted=1 until reset.
REQ-029 SHALL, with FCU_HALT_EN defined, ignore branch_taken and hold_req while in HALT.
REQ-030 SHALL, without FCU_HALT_EN, make HALT unreachable, tie halted to 0 and treat all-ones as an ordinary instruction.

Verification
REQ-031 SHALL cover: id_ex_memread=1, id_ex_rt=5, ins rs=5 -> stall/stall_pm/id_bubble=1 for one cycle, state 00->01->00, stall_cnt=1.
REQ-032 SHALL cover: ins=32'h0800_0040 in RUN -> pc_mux_sel=1, jmp_loc=16'h0040, stall=0, flush=0.
REQ-033 SHALL cover: branch_taken=1, branch_target=16'h0123 together with a hazard -> only the branch acts (flush=1, jmp_loc=16'h0123, id_bubble=0).
REQ-034 SHALL cover: hold_req high for 4 cycles -> stall=1 for 4 cycles, stall_cnt=4, RUN on the 5th cycle; reset pulsed during HOLD -> RUN, counters 0.
REQ-035 SHALL cover, with FCU_HALT_EN defined: ins=32'hFFFFFFFF -> halted=1 held through a later branch_taken=1; without the macro, halted stays 0.
REQ-036 SHALL cover: stall_cnt preloaded by 65535 stall cycles -> value stays 16'hFFFF on further stalls.
